// File: rtl/cache_mem_port_arbiter.sv
// Shares one memory request/response port between NUM_REQ cache controllers:
// round-robin grant locked per cache-line burst, in-order response routing via an ID FIFO.
module cache_mem_port_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned REQ_W           = 77,
    parameter int unsigned RESP_W          = 47,
    parameter int unsigned BURST_LEN       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_val,
    output logic [NUM_REQ-1:0]                   req_rdy,
    input  logic [NUM_REQ*REQ_W-1:0]             req_msg,
    output logic [NUM_REQ-1:0]                   resp_val,
    input  logic [NUM_REQ-1:0]                   resp_rdy,
    output logic [RESP_W-1:0]                    resp_msg,
    output logic                                 mem_req_val,
    input  logic                                 mem_req_rdy,
    output logic [REQ_W-1:0]                     mem_req_msg,
    input  logic                                 mem_resp_val,
    output logic                                 mem_resp_rdy,
    input  logic [RESP_W-1:0]                    mem_resp_msg,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_t;

    lock_state_t       state_q, state_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ID_W-1:0]   id_fifo_q [MAX_OUTSTANDING];

    logic [ID_W-1:0]   scan_id;
    logic              scan_found;
    logic [ID_W-1:0]   grant_id;
    logic              grant_vld;
    logic [ID_W-1:0]   head_id;
    logic              fifo_full;
    logic              fifo_empty;
    logic              req_fire;
    logic              resp_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // First requester with val set, scanning upward from rr_ptr with wrap.
    always_comb begin : rr_scan
        int unsigned idx;
        logic [ID_W-1:0] cand;
        idx        = 0;
        cand       = '0;
        scan_id    = '0;
        scan_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!scan_found && req_val[cand]) begin
                scan_id    = cand;
                scan_found = 1'b1;
            end
        end
    end

    assign grant_vld  = (state_q == ST_LOCKED) || scan_found;
    assign grant_id   = (state_q == ST_LOCKED) ? lock_id_q : scan_id;
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head_id    = id_fifo_q[head_q];

    assign mem_req_val  = !reset && grant_vld && req_val[grant_id] && !fifo_full;
    assign req_fire     = mem_req_val && mem_req_rdy;
    assign mem_resp_rdy = !reset && !fifo_empty && resp_rdy[head_id];
    assign resp_fire    = mem_resp_val && mem_resp_rdy;
    assign resp_msg     = mem_resp_msg;
    assign outstanding  = reset ? '0 : count_q;

    always_comb begin
        mem_req_msg = '0;
        req_rdy     = '0;
        resp_val    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                mem_req_msg = req_msg[i*REQ_W +: REQ_W];
                req_rdy[i]  = !reset && grant_vld && mem_req_rdy && !fifo_full;
            end
            if (ID_W'(i) == head_id) begin
                resp_val[i] = !reset && mem_resp_val && !fifo_empty;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (req_fire) begin
            tail_d = ptr_inc(tail_q);
            if (burst_cnt_q == BCNT_W'(BURST_LEN - 1)) begin
                burst_cnt_d = '0;
                state_d     = ST_OPEN;
                rr_ptr_d    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end else begin
                burst_cnt_d = burst_cnt_q + BCNT_W'(1);
                state_d     = ST_LOCKED;
                lock_id_d   = grant_id;
            end
        end
        if (resp_fire) begin
            head_d = ptr_inc(head_q);
        end
        count_d = count_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OPEN;
            lock_id_q   <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // ID storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            id_fifo_q[tail_q] <= grant_id;
        end
    end

endmodule

// File: tb/tb_cache_mem_port_arbiter.sv
// Directed bench for cache_mem_port_arbiter: burst lock, starvation, FIFO full,
// in-order response routing, back-pressure and mid-burst reset.
module tb_cache_mem_port_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned REQ_W   = 77;
    localparam int unsigned RESP_W  = 47;
    localparam int unsigned CNT_W   = 3;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_val;
    logic [NUM_REQ-1:0]       req_rdy;
    logic [NUM_REQ*REQ_W-1:0] req_msg;
    logic [NUM_REQ-1:0]       resp_val;
    logic [NUM_REQ-1:0]       resp_rdy;
    logic [RESP_W-1:0]        resp_msg;
    logic                     mem_req_val;
    logic                     mem_req_rdy;
    logic [REQ_W-1:0]         mem_req_msg;
    logic                     mem_resp_val;
    logic                     mem_resp_rdy;
    logic [RESP_W-1:0]        mem_resp_msg;
    logic [CNT_W-1:0]         outstanding;

    logic [REQ_W-1:0] m0;
    logic [REQ_W-1:0] m1;
    int errors;
    int checks;

    cache_mem_port_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .REQ_W          (REQ_W),
        .RESP_W         (RESP_W),
        .BURST_LEN      (4),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_msg     (req_msg),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_msg    (resp_msg),
        .mem_req_val (mem_req_val),
        .mem_req_rdy (mem_req_rdy),
        .mem_req_msg (mem_req_msg),
        .mem_resp_val(mem_resp_val),
        .mem_resp_rdy(mem_resp_rdy),
        .mem_resp_msg(mem_resp_msg),
        .outstanding (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_val      = '0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        resp_rdy     = '0;
        mem_resp_msg = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        req_val      = 2'b11;
        mem_req_rdy  = 1'b1;
        mem_resp_val = 1'b1;
        resp_rdy     = 2'b11;
        tick();
        #1;
        checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL rst_req_rdy: got %b expected 00", req_rdy); end
        checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL rst_mem_req_val: got %b expected 0", mem_req_val); end
        checks++; if (resp_val !== 2'b00) begin errors++; $display("FAIL rst_resp_val: got %b expected 00", resp_val); end
        checks++; if (mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL rst_mem_resp_rdy: got %b expected 0", mem_resp_rdy); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
        set_idle();
        reset = 1'b0;
        req_val = 2'b11;
        #1;
        checks++; if (mem_req_val !== 1'b1) begin errors++; $display("FAIL post_rst_val: got %b expected 1", mem_req_val); end
        checks++; if (mem_req_msg !== m0) begin errors++; $display("FAIL post_rst_msg: got %h expected %h", mem_req_msg, m0); end
    endtask

    task automatic test_burst_lock_and_starve();
        do_reset();
        req_val      = 2'b11;
        mem_req_rdy  = 1'b1;
        mem_resp_val = 1'b1;
        resp_rdy     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL burst0_rdy[%0d]: got %b expected 01", i, req_rdy); end
            checks++; if (mem_req_msg !== m0) begin errors++; $display("FAIL burst0_msg[%0d]: got %h expected %h", i, mem_req_msg, m0); end
            tick();
        end
        #1;
        checks++; if (req_rdy !== 2'b10) begin errors++; $display("FAIL fifth_rdy: got %b expected 10", req_rdy); end
        checks++; if (mem_req_msg !== m1) begin errors++; $display("FAIL fifth_msg: got %h expected %h", mem_req_msg, m1); end
        tick();
        #1;
        checks++; if (req_rdy !== 2'b10) begin errors++; $display("FAIL burst1_fire2_rdy: got %b expected 10", req_rdy); end
        tick();
        req_val = 2'b01;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL starve_val[%0d]: got %b expected 0", i, mem_req_val); end
            checks++; if (req_rdy[0] !== 1'b0) begin errors++; $display("FAIL starve_rdy0[%0d]: got %b expected 0", i, req_rdy[0]); end
            tick();
        end
        req_val = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (req_rdy !== 2'b10) begin errors++; $display("FAIL burst1_tail_rdy[%0d]: got %b expected 10", i, req_rdy); end
            tick();
        end
        mem_req_rdy = 1'b0;
        #1;
        checks++; if (mem_req_val !== 1'b1) begin errors++; $display("FAIL after_burst1_val: got %b expected 1", mem_req_val); end
        checks++; if (mem_req_msg !== m0) begin errors++; $display("FAIL after_burst1_msg: got %h expected %h", mem_req_msg, m0); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        req_val     = 2'b01;
        mem_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", outstanding); end
        checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL full_val: got %b expected 0", mem_req_val); end
        checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL full_rdy: got %b expected 00", req_rdy); end
        mem_resp_val = 1'b1;
        resp_rdy     = 2'b01;
        #1;
        checks++; if (mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL full_pop_rdy: got %b expected 1", mem_resp_rdy); end
        checks++; if (resp_val !== 2'b01) begin errors++; $display("FAIL full_pop_resp_val: got %b expected 01", resp_val); end
        checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b expected 0", mem_req_val); end
        tick();
        mem_resp_val = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL after_pop_count: got %0d expected 3", outstanding); end
        checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL after_pop_rdy: got %b expected 01", req_rdy); end
        tick();
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL refill_count: got %0d expected 4", outstanding); end
    endtask

    task automatic test_resp_routing();
        logic [1:0] exp_val;
        logic [RESP_W-1:0] rmsg;
        do_reset();
        req_val     = 2'b11;
        mem_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_resp_val = 1'b1;
        resp_rdy     = 2'b11;
        for (int i = 0; i < 8; i++) begin
            req_val      = (i < 5) ? 2'b10 : 2'b00;
            rmsg         = 47'(32'h0BEE_F000 + i);
            mem_resp_msg = rmsg;
            exp_val      = (i < 4) ? 2'b01 : 2'b10;
            #1;
            checks++; if (resp_val !== exp_val) begin errors++; $display("FAIL route_val[%0d]: got %b expected %b", i, resp_val, exp_val); end
            checks++; if (resp_msg !== rmsg) begin errors++; $display("FAIL route_msg[%0d]: got %h expected %h", i, resp_msg, rmsg); end
            tick();
        end
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL route_drained: got %0d expected 0", outstanding); end
    endtask

    task automatic test_resp_backpressure();
        do_reset();
        req_val     = 2'b10;
        mem_req_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 2'b10) begin errors++; $display("FAIL bp_push_rdy: got %b expected 10", req_rdy); end
        tick();
        req_val      = 2'b00;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b1;
        mem_resp_msg = 47'h1234_5678;
        resp_rdy     = 2'b01;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (resp_val !== 2'b10) begin errors++; $display("FAIL bp_resp_val[%0d]: got %b expected 10", i, resp_val); end
            checks++; if (mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL bp_hold_rdy[%0d]: got %b expected 0", i, mem_resp_rdy); end
            checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL bp_hold_count[%0d]: got %0d expected 1", i, outstanding); end
            tick();
        end
        resp_rdy = 2'b11;
        #1;
        checks++; if (mem_resp_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b expected 1", mem_resp_rdy); end
        tick();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL bp_drained: got %0d expected 0", outstanding); end
        checks++; if (mem_resp_rdy !== 1'b0) begin errors++; $display("FAIL empty_stray_rdy: got %b expected 0", mem_resp_rdy); end
        checks++; if (resp_val !== 2'b00) begin errors++; $display("FAIL empty_stray_val: got %b expected 00", resp_val); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_val     = 2'b10;
        mem_req_rdy = 1'b1;
        tick();
        tick();
        req_val = 2'b11;
        #1;
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL mid_count: got %0d expected 2", outstanding); end
        checks++; if (req_rdy !== 2'b10) begin errors++; $display("FAIL mid_locked_rdy: got %b expected 10", req_rdy); end
        reset = 1'b1;
        #1;
        checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL mid_rst_val: got %b expected 0", mem_req_val); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", outstanding); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL post_mid_count: got %0d expected 0", outstanding); end
        checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL post_mid_rdy: got %b expected 01", req_rdy); end
        checks++; if (mem_req_msg !== m0) begin errors++; $display("FAIL post_mid_msg: got %h expected %h", mem_req_msg, m0); end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        m0      = {13'h0AA, 64'h1111_2222_3333_4444};
        m1      = {13'h155, 64'h5555_6666_7777_8888};
        req_msg = {m1, m0};
        reset   = 1'b1;
        set_idle();
        test_reset();
        test_burst_lock_and_starve();
        test_fifo_full();
        test_resp_routing();
        test_resp_backpressure();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
